// File: rtl/musa_mem_arbiter.sv
// musa_mem_arbiter
//   Serialises accesses from three requesters onto the single-port MUSA data
//   memory. The loader (bit 0) always wins. The core (bit 1) and stack (bit 2)
//   share the rest round-robin. Each access takes MEM_LATENCY+3 cycles:
//   grant (IDLE), strobe (ACCESS), MEM_LATENCY wait cycles, done (RESP).
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   req/we           per-requester request and write flag (3 bits)
//   addr/wdata       per-requester address/write data, requester i at slice i
//   gnt              one-hot combinational grant, only in IDLE
//   done             one-hot completion pulse in RESP
//   rdata            read data, valid while done is set for a read
//   busy             access in flight
//   mem_*            fixed-latency memory port
module musa_mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              gnt,
  output logic [2:0]              done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ptr_q, ptr_d;     // 0: core first, 1: stack first
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [2:0]              win;

  // Winner selection; gated by rst so nothing is granted while in reset.
  always_comb begin
    win = '0;
    if (state_q == IDLE && !rst) begin
      if (req[0])                 win = 3'b001;
      else if (req[1] && req[2])  win = ptr_q ? 3'b100 : 3'b010;
      else if (req[1])            win = 3'b010;
      else if (req[2])            win = 3'b100;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (win != '0) begin
          state_d = ACCESS;
          for (int unsigned i = 0; i < 3; i++) begin
            if (win[i]) begin
              owner_d = 2'(i);
              we_d    = we[i];
              addr_d  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          // Core grant hands priority to stack and vice versa; loader leaves it.
          if (!win[0]) ptr_d = win[1];
        end
      end
      ACCESS: begin
        cnt_d   = 4'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; mem_addr/mem_wdata come straight from the capture registers so
  // they hold outside ACCESS.
  always_comb begin
    gnt       = win;
    done      = '0;
    if (state_q == RESP) done[owner_q] = 1'b1;
    busy      = (state_q != IDLE);
    mem_en    = (state_q == ACCESS);
    mem_we    = (state_q == ACCESS) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_musa_mem_arbiter.sv
// Directed bench for musa_mem_arbiter: instance 0 at MEM_LATENCY=2, instances
// 1 and 2 at MEM_LATENCY=1 and 15. Each has its own fixed-latency memory model
// that returns junk on every cycle except exactly MEM_LATENCY after mem_en.
module tb_musa_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req       [3];
  logic [2:0]  we        [3];
  logic [29:0] addr      [3];
  logic [95:0] wdata     [3];
  logic [2:0]  gnt       [3];
  logic [2:0]  done      [3];
  logic [31:0] rdata     [3];
  logic        busy      [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [9:0]  mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] init_val(input logic [9:0] a);
    if (a == 10'h025) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ {22'h0, a};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int LAT = (k == 0) ? 2 : (k == 1) ? 1 : 15;
    logic [31:0] wr_mem [1024];
    bit          wr_ok  [1024];
    logic [31:0] pipe   [16];

    always @(posedge clk) begin
      if (mem_en[k]) begin
        if (mem_we[k]) begin
          wr_mem[mem_addr[k]] <= mem_wdata[k];
          wr_ok[mem_addr[k]]  <= 1'b1;
        end
        pipe[0] <= wr_ok[mem_addr[k]] ? wr_mem[mem_addr[k]] : init_val(mem_addr[k]);
      end else begin
        pipe[0] <= 32'h0BAD0000 ^ cyc;
      end
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[k] = pipe[LAT-1];

    musa_mem_arbiter #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (10),
      .MEM_LATENCY(LAT)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req[k]),
      .we       (we[k]),
      .addr     (addr[k]),
      .wdata    (wdata[k]),
      .gnt      (gnt[k]),
      .done     (done[k]),
      .rdata    (rdata[k]),
      .busy     (busy[k]),
      .mem_en   (mem_en[k]),
      .mem_we   (mem_we[k]),
      .mem_addr (mem_addr[k]),
      .mem_wdata(mem_wdata[k]),
      .mem_rdata(mem_rdata[k])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int i = 0;
    while (busy[k] !== 1'b0 && i < 40) begin
      tick();
      i++;
    end
    if (busy[k] !== 1'b0) begin
      n_total++;
      $display("FAIL idle_timeout inst%0d busy=%b want 0", k, busy[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = 3'b000; we[k] = 3'b000; addr[k] = '0; wdata[k] = '0;
    end
    req[0] = 3'b111;
    repeat (3) begin
      tick();
      n_total++; if (gnt[0] !== 3'b000)    $display("FAIL rst_gnt got %b want 000", gnt[0]); else n_pass++;
      n_total++; if (done[0] !== 3'b000)   $display("FAIL rst_done got %b want 000", done[0]); else n_pass++;
      n_total++; if (rdata[0] !== 32'h0)   $display("FAIL rst_rdata got %h want 0", rdata[0]); else n_pass++;
      n_total++; if (busy[0] !== 1'b0)     $display("FAIL rst_busy got %b want 0", busy[0]); else n_pass++;
      n_total++; if (mem_en[0] !== 1'b0)   $display("FAIL rst_mem_en got %b want 0", mem_en[0]); else n_pass++;
      n_total++; if (mem_we[0] !== 1'b0)   $display("FAIL rst_mem_we got %b want 0", mem_we[0]); else n_pass++;
      n_total++; if (mem_addr[0] !== 10'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr[0]); else n_pass++;
      n_total++; if (mem_wdata[0] !== 32'h0) $display("FAIL rst_mem_wdata got %h want 0", mem_wdata[0]); else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_total++; if (gnt[0] !== 3'b001) $display("FAIL rst_release_gnt got %b want 001", gnt[0]); else n_pass++;
    tick();
    req[0] = 3'b000;
    wait_idle(0);
  endtask

  task automatic test_core_read();
    addr[0] = {10'h000, 10'h025, 10'h000};
    we[0]   = 3'b000;
    req[0]  = 3'b010;
    #1;
    n_total++; if (gnt[0] !== 3'b010) $display("FAIL rd_gnt got %b want 010", gnt[0]); else n_pass++;
    tick();
    req[0] = 3'b000;
    n_total++; if (mem_en[0] !== 1'b1)      $display("FAIL rd_mem_en got %b want 1", mem_en[0]); else n_pass++;
    n_total++; if (mem_addr[0] !== 10'h025) $display("FAIL rd_mem_addr got %h want 025", mem_addr[0]); else n_pass++;
    n_total++; if (mem_we[0] !== 1'b0)      $display("FAIL rd_mem_we got %b want 0", mem_we[0]); else n_pass++;
    n_total++; if (busy[0] !== 1'b1)        $display("FAIL rd_busy got %b want 1", busy[0]); else n_pass++;
    tick();
    tick();
    n_total++; if (done[0] !== 3'b000) $display("FAIL rd_done_early got %b want 000", done[0]); else n_pass++;
    tick();
    n_total++; if (done[0] !== 3'b010)        $display("FAIL rd_done got %b want 010", done[0]); else n_pass++;
    n_total++; if (rdata[0] !== 32'hDEADBEEF) $display("FAIL rd_rdata got %h want deadbeef", rdata[0]); else n_pass++;
    tick();
    n_total++; if (busy[0] !== 1'b0)   $display("FAIL rd_busy_end got %b want 0", busy[0]); else n_pass++;
    n_total++; if (done[0] !== 3'b000) $display("FAIL rd_done_end got %b want 000", done[0]); else n_pass++;
  endtask

  task automatic test_stack_write();
    addr[0]  = {10'h3FF, 20'h0};
    wdata[0] = {32'h12345678, 64'h0};
    we[0]    = 3'b100;
    req[0]   = 3'b100;
    #1;
    n_total++; if (gnt[0] !== 3'b100) $display("FAIL wr_gnt got %b want 100", gnt[0]); else n_pass++;
    tick();
    req[0] = 3'b000;
    we[0]  = 3'b000;
    n_total++; if (mem_en[0] !== 1'b1)            $display("FAIL wr_mem_en got %b want 1", mem_en[0]); else n_pass++;
    n_total++; if (mem_we[0] !== 1'b1)            $display("FAIL wr_mem_we got %b want 1", mem_we[0]); else n_pass++;
    n_total++; if (mem_addr[0] !== 10'h3FF)       $display("FAIL wr_mem_addr got %h want 3ff", mem_addr[0]); else n_pass++;
    n_total++; if (mem_wdata[0] !== 32'h12345678) $display("FAIL wr_mem_wdata got %h want 12345678", mem_wdata[0]); else n_pass++;
    tick();
    n_total++; if (mem_we[0] !== 1'b0) $display("FAIL wr_mem_we_off got %b want 0", mem_we[0]); else n_pass++;
    tick();
    tick();
    n_total++; if (done[0] !== 3'b100)        $display("FAIL wr_done got %b want 100", done[0]); else n_pass++;
    n_total++; if (rdata[0] !== 32'hDEADBEEF) $display("FAIL wr_rdata_kept got %h want deadbeef", rdata[0]); else n_pass++;
    tick();
  endtask

  task automatic test_fairness();
    logic       rl = 1'b0, rc = 1'b1, rs = 1'b1;
    logic [2:0] exp_g, exp_d;
    addr[0] = {10'h022, 10'h011, 10'h000};
    for (int c = 0; c < 30; c++) begin
      req[0] = {rs, rc, rl};
      #1;
      case (c)
        0, 10, 25: exp_g = 3'b010;
        5, 15:     exp_g = 3'b100;
        20:        exp_g = 3'b001;
        default:   exp_g = 3'b000;
      endcase
      case (c)
        4, 14, 29: exp_d = 3'b010;
        9, 19:     exp_d = 3'b100;
        24:        exp_d = 3'b001;
        default:   exp_d = 3'b000;
      endcase
      n_total++; if (gnt[0] !== exp_g)  $display("FAIL fair_gnt c%0d got %b want %b", c, gnt[0], exp_g); else n_pass++;
      n_total++; if (done[0] !== exp_d) $display("FAIL fair_done c%0d got %b want %b", c, done[0], exp_d); else n_pass++;
      if (gnt[0][0]) rl = 1'b0;
      if (gnt[0][1]) rc = 1'b0;
      if (gnt[0][2]) rs = 1'b0;
      if (done[0][1]) rc = 1'b1;
      if (done[0][2]) rs = 1'b1;
      if (c == 17) rl = 1'b1;
      tick();
    end
    req[0] = 3'b000;
    wait_idle(0);
  endtask

  task automatic test_reset_mid_access();
    addr[0] = '0;
    req[0]  = 3'b001;
    #1;
    n_total++; if (gnt[0] !== 3'b001) $display("FAIL mid_gnt got %b want 001", gnt[0]); else n_pass++;
    tick();
    req[0] = 3'b000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (busy[0] !== 1'b0) $display("FAIL mid_busy got %b want 0", busy[0]); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_total++; if (done[0] !== 3'b000) $display("FAIL mid_no_done c%0d got %b want 000", c, done[0]); else n_pass++;
      tick();
    end
    req[0] = 3'b110;
    #1;
    n_total++; if (gnt[0] !== 3'b010) $display("FAIL mid_ptr_gnt got %b want 010", gnt[0]); else n_pass++;
    tick();
    req[0] = 3'b000;
    wait_idle(0);
  endtask

  task automatic test_latency_sweep();
    for (int k = 1; k < 3; k++) begin
      int lat = (k == 1) ? 1 : 15;
      logic [2:0] exp_d;
      addr[k] = {10'h000, 10'h100, 10'h000};
      we[k]   = 3'b000;
      req[k]  = 3'b010;
      #1;
      n_total++; if (gnt[k] !== 3'b010) $display("FAIL lat%0d_gnt got %b want 010", lat, gnt[k]); else n_pass++;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (c == 1) req[k] = 3'b000;
        exp_d = (c == 2 + lat) ? 3'b010 : 3'b000;
        n_total++; if (done[k] !== exp_d) $display("FAIL lat%0d_done c%0d got %b want %b", lat, c, done[k], exp_d); else n_pass++;
        if (c == 2 + lat) begin
          n_total++; if (rdata[k] !== 32'hC0DE0100) $display("FAIL lat%0d_rdata got %h want c0de0100", lat, rdata[k]); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_stack_write();
    test_fairness();
    test_reset_mid_access();
    test_latency_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
